// File: rtl/sparc_ifu_swhint_pkg.sv
// Shared encodings and default sizes for the IFU switch-hint tracker.
package sparc_ifu_swhint_pkg;

    localparam int unsigned NTHR_DEF = 4;
    localparam int unsigned TIDW_DEF = 2;
    localparam int unsigned CNTW_DEF = 16;

    // Encoding 2'b11 is illegal and decodes to SW_RUN.
    typedef enum logic [1:0] {
        SW_RUN   = 2'b00,
        SW_SWREQ = 2'b01,
        SW_WAIT  = 2'b10
    } sw_state_e;

endpackage

// File: rtl/sparc_ifu_swhint_thr.sv
// One thread's switch FSM (RUN -> SWREQ -> WAIT -> RUN) and, when SWHINT_PERF_CNT_EN
// is defined, a saturating count of SWREQ->WAIT transitions.
module sparc_ifu_swhint_thr
    import sparc_ifu_swhint_pkg::*;
#(
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic            rclk,
    input  logic            reset,
    input  logic            hit,
    input  logic            gnt,
    input  logic            cmpl,
    output sw_state_e       state_nxt_c,
    output logic            drop_c,
    output logic [CNTW-1:0] sw_cnt
);

    sw_state_e state_q;

    always_ff @(posedge rclk) begin
        if (reset) state_q <= SW_RUN;
        else       state_q <= state_nxt_c;
    end

    // Completion outranks a same-cycle grant; hints on a parked thread are dropped.
    always_comb begin
        state_nxt_c = state_q;
        drop_c      = 1'b0;
        case (state_q)
            SW_SWREQ: begin
                drop_c = hit;
                if (cmpl)     state_nxt_c = SW_RUN;
                else if (gnt) state_nxt_c = SW_WAIT;
            end
            SW_WAIT: begin
                drop_c = hit;
                if (cmpl) state_nxt_c = SW_RUN;
            end
            default: begin
                if (hit) state_nxt_c = SW_SWREQ;
                else     state_nxt_c = SW_RUN;
            end
        endcase
    end

`ifdef SWHINT_PERF_CNT_EN
    logic            to_wait_c;
    logic [CNTW-1:0] cnt_q;

    assign to_wait_c = (state_q == SW_SWREQ) && (state_nxt_c == SW_WAIT);

    always_ff @(posedge rclk) begin
        if (reset)
            cnt_q <= '0;
        else if (to_wait_c && (cnt_q != {CNTW{1'b1}}))
            cnt_q <= cnt_q + CNTW'(1);
    end

    assign sw_cnt = cnt_q;
`else
    assign sw_cnt = '0;
`endif

endmodule

// File: rtl/sparc_ifu_swhint.sv
// Per-thread switch-hint tracking with a round-robin, one-at-a-time switch request.
// Optional per-thread switch counters are built when SWHINT_PERF_CNT_EN is defined.
module sparc_ifu_swhint
    import sparc_ifu_swhint_pkg::*;
#(
    parameter int unsigned NTHR = NTHR_DEF,
    parameter int unsigned TIDW = TIDW_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic                 rclk,
    input  logic                 reset,
    input  logic                 fetch_vld,
    input  logic                 fetch_kill,
    input  logic [TIDW-1:0]      fetch_tid,
    input  logic                 swpla_out,
    input  logic                 swl_switch_gnt,
    input  logic [NTHR-1:0]      cmpl_vld,
    output logic                 swl_switch_req,
    output logic [TIDW-1:0]      swl_req_tid,
    output logic [NTHR-1:0]      thr_ready,
    output logic                 swl_drop_hint,
    output logic [NTHR*CNTW-1:0] swl_sw_cnt
);

    logic [NTHR-1:0] hit_c;
    logic [NTHR-1:0] thr_gnt_c;
    logic [NTHR-1:0] drop_vec_c;
    logic [NTHR-1:0] swreq_nxt_c;
    logic [NTHR-1:0] run_nxt_c;
    sw_state_e       state_nxt_c [NTHR];

    logic [TIDW-1:0] ptr_q;
    logic [TIDW-1:0] ptr_d;
    logic            req_d;
    logic [TIDW-1:0] tid_d;
    logic            found_c;
    logic [TIDW-1:0] pick_c;
    logic [TIDW-1:0] idx_c;

    for (genvar t = 0; t < NTHR; t++) begin : g_thr
        assign hit_c[t]     = fetch_vld & ~fetch_kill & swpla_out & (fetch_tid == TIDW'(t));
        assign thr_gnt_c[t] = swl_switch_req & swl_switch_gnt & (swl_req_tid == TIDW'(t));

        sparc_ifu_swhint_thr #(.CNTW(CNTW)) u_thr (
            .rclk        (rclk),
            .reset       (reset),
            .hit         (hit_c[t]),
            .gnt         (thr_gnt_c[t]),
            .cmpl        (cmpl_vld[t]),
            .state_nxt_c (state_nxt_c[t]),
            .drop_c      (drop_vec_c[t]),
            .sw_cnt      (swl_sw_cnt[t*CNTW +: CNTW])
        );

        assign swreq_nxt_c[t] = (state_nxt_c[t] == SW_SWREQ);
        assign run_nxt_c[t]   = (state_nxt_c[t] == SW_RUN);
    end

    // Round-robin pick among threads that will be in SWREQ next cycle, starting at ptr_q.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = '0;
        for (int i = 0; i < int'(NTHR); i++) begin
            idx_c = ptr_q + TIDW'(i);
            if (!found_c && swreq_nxt_c[idx_c]) begin
                found_c = 1'b1;
                pick_c  = idx_c;
            end
        end
    end

    // A held request drops after a grant or a withdrawing completion; a new one starts only from idle.
    always_comb begin
        req_d = swl_switch_req;
        tid_d = swl_req_tid;
        ptr_d = ptr_q;
        if (swl_switch_req) begin
            if (cmpl_vld[swl_req_tid]) begin
                req_d = 1'b0;
            end else if (swl_switch_gnt) begin
                req_d = 1'b0;
                ptr_d = swl_req_tid + TIDW'(1);
            end
        end else if (found_c) begin
            req_d = 1'b1;
            tid_d = pick_c;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            swl_switch_req <= 1'b0;
            swl_req_tid    <= '0;
            ptr_q          <= '0;
            thr_ready      <= '1;
            swl_drop_hint  <= 1'b0;
        end else begin
            swl_switch_req <= req_d;
            swl_req_tid    <= tid_d;
            ptr_q          <= ptr_d;
            thr_ready      <= run_nxt_c;
            swl_drop_hint  <= |drop_vec_c;
        end
    end

endmodule

// File: tb/tb_sparc_ifu_swhint.sv
// Directed bench for sparc_ifu_swhint with a grant-order scoreboard.
// Build with SWHINT_PERF_CNT_EN defined to also exercise counter saturation (narrow CNTW).
module tb_sparc_ifu_swhint;

    localparam int unsigned TB_NTHR = 4;
    localparam int unsigned TB_TIDW = 2;
    localparam int unsigned TB_CNTW = 4;

    logic                         rclk;
    logic                         reset;
    logic                         fetch_vld;
    logic                         fetch_kill;
    logic [TB_TIDW-1:0]           fetch_tid;
    logic                         swpla_out;
    logic                         swl_switch_gnt;
    logic [TB_NTHR-1:0]           cmpl_vld;
    logic                         swl_switch_req;
    logic [TB_TIDW-1:0]           swl_req_tid;
    logic [TB_NTHR-1:0]           thr_ready;
    logic                         swl_drop_hint;
    logic [TB_NTHR*TB_CNTW-1:0]   swl_sw_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [TB_TIDW-1:0] exp_q [$];
    logic [TB_TIDW-1:0] exp_tid;
    logic [15:0]        exp_cnt;

    sparc_ifu_swhint #(.NTHR(TB_NTHR), .TIDW(TB_TIDW), .CNTW(TB_CNTW)) dut (
        .rclk           (rclk),
        .reset          (reset),
        .fetch_vld      (fetch_vld),
        .fetch_kill     (fetch_kill),
        .fetch_tid      (fetch_tid),
        .swpla_out      (swpla_out),
        .swl_switch_gnt (swl_switch_gnt),
        .cmpl_vld       (cmpl_vld),
        .swl_switch_req (swl_switch_req),
        .swl_req_tid    (swl_req_tid),
        .thr_ready      (thr_ready),
        .swl_drop_hint  (swl_drop_hint),
        .swl_sw_cnt     (swl_sw_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; an effective grant sampled at this edge is scored against the queue.
    task automatic cyc();
        if (!reset && swl_switch_req === 1'b1 && swl_switch_gnt && !cmpl_vld[swl_req_tid]) begin
            n_chk++;
            assert (exp_q.size() > 0)
            else begin
                n_fail++;
                $error("FAIL sb_unexpected_grant observed_tid=%0d expected=none", swl_req_tid);
            end
            if (exp_q.size() > 0) begin
                exp_tid = exp_q.pop_front();
                chk("grant_tid", 32'(swl_req_tid), 32'(exp_tid));
            end
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic hint(input logic [TB_TIDW-1:0] tid);
        fetch_vld = 1'b1; fetch_kill = 1'b0; swpla_out = 1'b1; fetch_tid = tid;
    endtask

    task automatic no_fetch();
        fetch_vld = 1'b0; fetch_kill = 1'b0; swpla_out = 1'b0; fetch_tid = '0;
    endtask

    initial begin
        reset = 1'b1; no_fetch(); swl_switch_gnt = 1'b0; cmpl_vld = '0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_req", 32'(swl_switch_req), 32'd0);
        chk("rst_tid", 32'(swl_req_tid), 32'd0);
        chk("rst_ready", 32'(thr_ready), 32'hF);
        chk("rst_drop", 32'(swl_drop_hint), 32'd0);
        chk("rst_cnt", 32'(swl_sw_cnt), 32'd0);

        // 1: single hint on tid2, grant, completion
        hint(2); cyc(); no_fetch();
        chk("t1_req", 32'(swl_switch_req), 32'd1);
        chk("t1_tid", 32'(swl_req_tid), 32'd2);
        chk("t1_ready_n1", 32'(thr_ready), 32'hB);
        swl_switch_gnt = 1'b1; exp_q.push_back(2); cyc(); swl_switch_gnt = 1'b0;
        chk("t1_req_drop", 32'(swl_switch_req), 32'd0);
        chk("t1_ready_n2", 32'(thr_ready), 32'hB);
        cyc(); cyc();
        chk("t1_ready_n4", 32'(thr_ready), 32'hB);
        cmpl_vld = 4'b0100; cyc(); cmpl_vld = '0;
        chk("t1_ready_n6", 32'(thr_ready), 32'hF);
        chk("t1_drop", 32'(swl_drop_hint), 32'd0);

        // 2: back-to-back hints tid0/tid1 with grant held
        exp_q.push_back(0); exp_q.push_back(1);
        hint(0); cyc();
        chk("t2_req0", 32'(swl_switch_req), 32'd1);
        chk("t2_tid0", 32'(swl_req_tid), 32'd0);
        hint(1); swl_switch_gnt = 1'b1; cyc(); no_fetch();
        chk("t2_bubble", 32'(swl_switch_req), 32'd0);
        cyc();
        chk("t2_req1", 32'(swl_switch_req), 32'd1);
        chk("t2_tid1", 32'(swl_req_tid), 32'd1);
        cyc(); swl_switch_gnt = 1'b0;
        chk("t2_req_off", 32'(swl_switch_req), 32'd0);
        chk("t2_ready", 32'(thr_ready), 32'hC);
        cmpl_vld = 4'b0011; cyc(); cmpl_vld = '0;
        chk("t2_ready_back", 32'(thr_ready), 32'hF);

        // 3: completion beats same-cycle grant on tid3
        hint(3); cyc(); no_fetch();
        chk("t3_tid", 32'(swl_req_tid), 32'd3);
        swl_switch_gnt = 1'b1; cmpl_vld = 4'b1000; cyc();
        swl_switch_gnt = 1'b0; cmpl_vld = '0;
        chk("t3_req", 32'(swl_switch_req), 32'd0);
        chk("t3_ready", 32'(thr_ready), 32'hF);
        chk("t3_cnt", 32'(swl_sw_cnt[15:12]), 32'd0);

        // 4: killed hint ignored; stray grant ignored; hint on parked thread dropped
        hint(1); fetch_kill = 1'b1; cyc(); no_fetch();
        chk("t4_kill_ready", 32'(thr_ready), 32'hF);
        chk("t4_kill_req", 32'(swl_switch_req), 32'd0);
        swl_switch_gnt = 1'b1; cyc(); swl_switch_gnt = 1'b0;
        chk("t4_gnt_idle", 32'(swl_switch_req), 32'd0);
        hint(1); cyc(); no_fetch();
        swl_switch_gnt = 1'b1; exp_q.push_back(1); cyc(); swl_switch_gnt = 1'b0;
        chk("t4_wait_ready", 32'(thr_ready), 32'hD);
        hint(1); cyc(); no_fetch();
        chk("t4_drop_on", 32'(swl_drop_hint), 32'd1);
        chk("t4_drop_ready", 32'(thr_ready), 32'hD);
        chk("t4_drop_req", 32'(swl_switch_req), 32'd0);
        cyc();
        chk("t4_drop_off", 32'(swl_drop_hint), 32'd0);
        cmpl_vld = 4'b0010; cyc(); cmpl_vld = '0;
        chk("t4_ready_back", 32'(thr_ready), 32'hF);

        // 5: all four threads requesting, round-robin order
        for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
        for (int i = 0; i < 4; i++) begin
            hint(2'(i)); cyc();
        end
        no_fetch();
        chk("t5_all_swreq", 32'(thr_ready), 32'h0);
        swl_switch_gnt = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        swl_switch_gnt = 1'b0;
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_req_off", 32'(swl_switch_req), 32'd0);
        cmpl_vld = 4'b1111; cyc(); cmpl_vld = '0;
        chk("t5_ready_back", 32'(thr_ready), 32'hF);

        // 5b: pointer wrapped to 0 -> re-arbitration after withdrawal favours tid0 over tid3
        hint(1); cyc(); hint(3); cyc(); hint(0); cyc(); no_fetch();
        chk("t5b_held_tid", 32'(swl_req_tid), 32'd1);
        cmpl_vld = 4'b0010; cyc(); cmpl_vld = '0;
        chk("t5b_withdraw", 32'(swl_switch_req), 32'd0);
        cyc();
        chk("t5b_req", 32'(swl_switch_req), 32'd1);
        chk("t5b_tid", 32'(swl_req_tid), 32'd0);
        swl_switch_gnt = 1'b1; exp_q.push_back(0); cyc(); swl_switch_gnt = 1'b0;
        cyc();
        chk("t5b_next_tid", 32'(swl_req_tid), 32'd3);
        cmpl_vld = 4'b1001; cyc(); cmpl_vld = '0;
        chk("t5b_req_off", 32'(swl_switch_req), 32'd0);
        chk("t5b_ready", 32'(thr_ready), 32'hF);
`ifdef SWHINT_PERF_CNT_EN
        exp_cnt = 16'h1233;
`else
        exp_cnt = 16'h0000;
`endif
        chk("t5b_cnt", 32'(swl_sw_cnt), 32'(exp_cnt));

        // 6: reset during an active request with grant
        hint(2); cyc(); no_fetch();
        chk("t6_req_pre", 32'(swl_switch_req), 32'd1);
        swl_switch_gnt = 1'b1; reset = 1'b1; cyc();
        reset = 1'b0; swl_switch_gnt = 1'b0;
        chk("t6_req", 32'(swl_switch_req), 32'd0);
        chk("t6_tid", 32'(swl_req_tid), 32'd0);
        chk("t6_ready", 32'(thr_ready), 32'hF);
        chk("t6_drop", 32'(swl_drop_hint), 32'd0);
        chk("t6_cnt", 32'(swl_sw_cnt), 32'd0);
        cyc();
        chk("t6_req_after", 32'(swl_switch_req), 32'd0);

`ifdef SWHINT_PERF_CNT_EN
        // Counter saturation on tid0 with a narrow counter
        for (int i = 0; i < (1 << TB_CNTW) + 1; i++) begin
            hint(0); cyc(); no_fetch();
            swl_switch_gnt = 1'b1; exp_q.push_back(0); cyc(); swl_switch_gnt = 1'b0;
            chk("cnt_tid0", 32'(swl_sw_cnt[3:0]), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            cmpl_vld = 4'b0001; cyc(); cmpl_vld = '0;
        end
        chk("cnt_others", 32'(swl_sw_cnt[15:4]), 32'd0);
`endif

        chk("sb_final_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
